// File: rtl/adder_result_accumulator.sv
// Adder result accumulator: sums NUM_BEATS adder results per run and
// presents the total on a valid/ready output with a sticky overflow flag.
module adder_result_accumulator #(
    parameter int IN_WIDTH  = 3,
    parameter int ACC_WIDTH = 8,
    parameter int NUM_BEATS = 16
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic                               Start,
    input  logic                               Clear,
    input  logic                               In_valid,
    input  logic [IN_WIDTH-1:0]                In_data,
    output logic                               In_ready,
    output logic                               Out_valid,
    input  logic                               Out_ready,
    output logic [ACC_WIDTH-1:0]               Acc_out,
    output logic                               Overflow,
    output logic [$clog2(NUM_BEATS+1)-1:0]     Beat_count,
    output logic                               Busy
);

    localparam int CW = $clog2(NUM_BEATS + 1);
    localparam int SW = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        sum;

    // One extra bit catches the carry out of the accumulator
    assign sum = {1'b0, acc_q} + SW'(In_data);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (Clear) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                ACCUM: begin
                    if (In_valid) begin
                        acc_d = sum[ACC_WIDTH-1:0];
                        ovf_d = ovf_q | sum[ACC_WIDTH];
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(NUM_BEATS - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign In_ready   = (state_q == ACCUM);
    assign Out_valid  = (state_q == DONE);
    assign Busy       = (state_q != IDLE);
    assign Acc_out    = acc_q;
    assign Overflow   = ovf_q;
    assign Beat_count = cnt_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator: default instance plus a
// narrow ACC_WIDTH=6 instance sharing the same input stream.
module tb_adder_result_accumulator;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic       Clear = 1'b0;
    logic       In_valid = 1'b0;
    logic [2:0] In_data = 3'd0;
    logic       Out_ready = 1'b0;

    logic       In_ready, Out_valid, Overflow, Busy;
    logic [7:0] Acc_out;
    logic [4:0] Beat_count;

    logic       In_ready6, Out_valid6, Overflow6, Busy6;
    logic [5:0] Acc_out6;
    logic [4:0] Beat_count6;

    int errors = 0;
    int checks = 0;

    adder_result_accumulator dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Clear(Clear),
        .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Acc_out(Acc_out),
        .Overflow(Overflow), .Beat_count(Beat_count), .Busy(Busy)
    );

    adder_result_accumulator #(.ACC_WIDTH(6)) dut6 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Clear(Clear),
        .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready6),
        .Out_valid(Out_valid6), .Out_ready(Out_ready), .Acc_out(Acc_out6),
        .Overflow(Overflow6), .Beat_count(Beat_count6), .Busy(Busy6)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_run();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic handshake();
        Out_ready = 1'b1;
        step();
        Out_ready = 1'b0;
        checks++;
        if (Out_valid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake_idle got valid=%0b busy=%0b exp 0 0",
                     Out_valid, Busy);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        step();
        step();
        checks++;
        if (In_ready !== 1'b0 || Out_valid !== 1'b0 || Busy !== 1'b0 ||
            Acc_out !== 8'd0 || Overflow !== 1'b0 || Beat_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%0b vld=%0b busy=%0b acc=%0d ovf=%0b cnt=%0d exp all 0",
                     In_ready, Out_valid, Busy, Acc_out, Overflow, Beat_count);
        end
        Rst_n = 1'b1;
        step();
        checks++;
        if (Busy !== 1'b0 || In_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%0b rdy=%0b exp 0 0", Busy, In_ready);
        end
    endtask

    // Feed A+B for every {A,B} in 0..15; total is 48
    task automatic feed_stream(input bit gaps);
        logic [3:0] ab;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                In_valid = 1'b0;
                In_data  = 3'd7;
                step();
                if (i == 15) begin
                    checks++;
                    if (Out_valid !== 1'b0 || Beat_count !== 5'd15) begin
                        errors++;
                        $display("FAIL gap_ignored got vld=%0b cnt=%0d exp 0 15",
                                 Out_valid, Beat_count);
                    end
                end
            end
            ab = 4'(i);
            In_valid = 1'b1;
            In_data  = {1'b0, ab[3:2]} + {1'b0, ab[1:0]};
            if (i == 15) begin
                checks++;
                if (Out_valid !== 1'b0 || In_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL pre_last got vld=%0b rdy=%0b exp 0 1",
                             Out_valid, In_ready);
                end
            end
            step();
        end
        In_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        start_run();
        checks++;
        if (In_ready !== 1'b1 || Busy !== 1'b1 || Acc_out !== 8'd0) begin
            errors++;
            $display("FAIL accum_entry got rdy=%0b busy=%0b acc=%0d exp 1 1 0",
                     In_ready, Busy, Acc_out);
        end
        feed_stream(1'b0);
        checks++;
        if (Out_valid !== 1'b1 || Acc_out !== 8'd48 || Overflow !== 1'b0 ||
            Beat_count !== 5'd16) begin
            errors++;
            $display("FAIL b2b_total got vld=%0b acc=%0d ovf=%0b cnt=%0d exp 1 48 0 16",
                     Out_valid, Acc_out, Overflow, Beat_count);
        end
    endtask

    task automatic test_hold_done();
        for (int i = 0; i < 5; i++) begin
            Start = i[0];
            step();
            checks++;
            if (Out_valid !== 1'b1 || Acc_out !== 8'd48 || In_ready !== 1'b0 ||
                Beat_count !== 5'd16) begin
                errors++;
                $display("FAIL done_hold%0d got vld=%0b acc=%0d rdy=%0b cnt=%0d exp 1 48 0 16",
                         i, Out_valid, Acc_out, In_ready, Beat_count);
            end
        end
        Start = 1'b0;
        handshake();
        checks++;
        if (Acc_out !== 8'd48 || Beat_count !== 5'd16) begin
            errors++;
            $display("FAIL idle_hold got acc=%0d cnt=%0d exp 48 16", Acc_out, Beat_count);
        end
    endtask

    task automatic test_gaps();
        start_run();
        feed_stream(1'b1);
        checks++;
        if (Out_valid !== 1'b1 || Acc_out !== 8'd48 || Beat_count !== 5'd16) begin
            errors++;
            $display("FAIL gap_total got vld=%0b acc=%0d cnt=%0d exp 1 48 16",
                     Out_valid, Acc_out, Beat_count);
        end
        handshake();
    endtask

    task automatic test_overflow();
        start_run();
        for (int i = 0; i < 16; i++) begin
            In_valid = 1'b1;
            In_data  = 3'd6;
            step();
            if (i == 9) begin
                checks++;
                if (Overflow6 !== 1'b0 || Acc_out6 !== 6'd60) begin
                    errors++;
                    $display("FAIL ovf_before got ovf=%0b acc=%0d exp 0 60",
                             Overflow6, Acc_out6);
                end
            end
            if (i == 10) begin
                checks++;
                if (Overflow6 !== 1'b1 || Acc_out6 !== 6'd2) begin
                    errors++;
                    $display("FAIL ovf_wrap got ovf=%0b acc=%0d exp 1 2",
                             Overflow6, Acc_out6);
                end
            end
        end
        In_valid = 1'b0;
        checks++;
        if (Out_valid6 !== 1'b1 || Acc_out6 !== 6'd32 || Overflow6 !== 1'b1) begin
            errors++;
            $display("FAIL ovf6_total got vld=%0b acc=%0d ovf=%0b exp 1 32 1",
                     Out_valid6, Acc_out6, Overflow6);
        end
        checks++;
        if (Acc_out !== 8'd96 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL wide_total got acc=%0d ovf=%0b exp 96 0", Acc_out, Overflow);
        end
        step();
        step();
        checks++;
        if (Overflow6 !== 1'b1 || Acc_out6 !== 6'd32 || Out_valid6 !== 1'b1) begin
            errors++;
            $display("FAIL ovf6_hold got ovf=%0b acc=%0d vld=%0b exp 1 32 1",
                     Overflow6, Acc_out6, Out_valid6);
        end
        handshake();
        start_run();
        checks++;
        if (Overflow6 !== 1'b0 || Acc_out6 !== 6'd0) begin
            errors++;
            $display("FAIL ovf6_restart got ovf=%0b acc=%0d exp 0 0", Overflow6, Acc_out6);
        end
        Clear = 1'b1;
        step();
        Clear = 1'b0;
    endtask

    task automatic test_async_reset();
        start_run();
        for (int i = 0; i < 7; i++) begin
            In_valid = 1'b1;
            In_data  = 3'd3;
            step();
        end
        In_valid = 1'b0;
        checks++;
        if (Beat_count !== 5'd7 || Acc_out !== 8'd21) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d acc=%0d exp 7 21", Beat_count, Acc_out);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (Acc_out !== 8'd0 || Beat_count !== 5'd0 || Busy !== 1'b0 ||
            In_ready !== 1'b0 || Out_valid !== 1'b0 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got acc=%0d cnt=%0d busy=%0b rdy=%0b exp 0 0 0 0",
                     Acc_out, Beat_count, Busy, In_ready);
        end
        #1;
        Rst_n = 1'b1;
        step();
        start_run();
        for (int i = 0; i < 16; i++) begin
            In_valid = 1'b1;
            In_data  = 3'd1;
            step();
        end
        In_valid = 1'b0;
        checks++;
        if (Out_valid !== 1'b1 || Acc_out !== 8'd16) begin
            errors++;
            $display("FAIL post_reset got vld=%0b acc=%0d exp 1 16", Out_valid, Acc_out);
        end
        handshake();
    endtask

    task automatic test_clear();
        Start = 1'b1;
        Clear = 1'b1;
        step();
        Start = 1'b0;
        Clear = 1'b0;
        checks++;
        if (Busy !== 1'b0 || In_ready !== 1'b0 || Acc_out !== 8'd0) begin
            errors++;
            $display("FAIL clear_wins got busy=%0b rdy=%0b acc=%0d exp 0 0 0",
                     Busy, In_ready, Acc_out);
        end
        start_run();
        for (int i = 0; i < 3; i++) begin
            In_valid = 1'b1;
            In_data  = 3'd5;
            step();
        end
        checks++;
        if (Beat_count !== 5'd3 || Acc_out !== 8'd15) begin
            errors++;
            $display("FAIL clear_pre got cnt=%0d acc=%0d exp 3 15", Beat_count, Acc_out);
        end
        In_data = 3'd7;
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        In_valid = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Beat_count !== 5'd0 || Acc_out !== 8'd0 ||
            In_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_accum got busy=%0b cnt=%0d acc=%0d rdy=%0b exp 0 0 0 0",
                     Busy, Beat_count, Acc_out, In_ready);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold_done();
        test_gaps();
        test_overflow();
        test_async_reset();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_result_accumulator.md
Name: adder_result_accumulator

Overview:
- Downstream consumer of the synchronous 2-bit adder stage.
- Accepts the adder's 3-bit registered result ({Carry_reg, Sum_reg}) as a valid/ready stream.
- Sums a programmed number of results into a wider accumulator and presents the total on a valid/ready output with a sticky overflow flag.
- Used for throughput tests and for reducing adder result streams to a checksum.

Parameters:
- IN_WIDTH, 3, width of one adder result (carry plus sum).
- ACC_WIDTH, 8, accumulator and output width; must be greater than IN_WIDTH.
- NUM_BEATS, 16, number of input beats summed per run; must be at least 1.

Ports:
- Clk  input  1  single clock; all state updates on its rising edge.
- Rst_n  input  1  reset; asynchronous, active-low.
- Start  input  1  one-cycle run request; honoured only in IDLE.
- Clear  input  1  synchronous abort; returns the block to IDLE from any state.
- In_valid  input  1  In_data holds a valid adder result.
- In_data  input  IN_WIDTH  adder result, i.e. {Carry_reg, Sum_reg}.
- In_ready  output  1  block accepts a beat this cycle.
- Out_valid  output  1  Acc_out holds a completed total.
- Out_ready  input  1  downstream takes the total.
- Acc_out  output  ACC_WIDTH  accumulated total.
- Overflow  output  1  sticky; set if any addition in the current run carried out of ACC_WIDTH.
- Beat_count  output  clog2(NUM_BEATS+1)  beats accepted in the current run.
- Busy  output  1  high in ACCUM and DONE.

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE. In_ready, Out_valid, Acc_out, Overflow, Beat_count and Busy are all 0. Reset takes effect immediately, including mid-run; no partial result survives.
- State IDLE: In_ready=0, Out_valid=0, Busy=0. Acc_out, Overflow and Beat_count hold their last values.
  - Start=1 and Clear=0: clear the accumulator, Overflow and Beat_count, then go to ACCUM on the next cycle.
- State ACCUM: In_ready=1, Busy=1.
  - Each cycle with In_valid and In_ready both high is one accepted beat: the accumulator takes acc + zero-extended In_data, modulo 2^ACC_WIDTH, and Beat_count increments.
  - Overflow is set if that addition carries out of bit ACC_WIDTH-1. Once set it stays set until the next Start or reset.
  - Cycles with In_valid low change nothing. In_data is a don't-care when In_valid is low.
  - The beat that brings Beat_count to NUM_BEATS goes to DONE on the next cycle; that final beat is included in the total.
- State DONE: Out_valid=1, In_ready=0, Busy=1.
  - Acc_out, Overflow and Beat_count stay stable while Out_valid=1 and Out_ready=0.
  - The cycle with Out_valid and Out_ready both high completes the handshake; next state is IDLE.
- Latency: Out_valid rises in the cycle after the final beat is accepted. With back-to-back valid input, a run takes NUM_BEATS+1 cycles from the first ACCUM cycle to Out_valid.
- Clear=1 in any state: the next state is IDLE. Accumulator, Overflow and Beat_count are cleared. No beat is accepted in that cycle; In_ready stays as defined for the current state, but any beat presented in that cycle is dropped.
- Start while in ACCUM or DONE: ignored.
- Clear and Start asserted together in IDLE: Clear wins, and the block stays in IDLE.
- Acc_out is driven directly from the accumulator register, with no combinational path from inputs to outputs.
- In_ready depends only on state.

Test Plan:
- Default parameters; feed 16 back-to-back beats of A+B for every {A,B} combination 0..15 -> Out_valid rises 1 cycle after the 16th beat; Acc_out=48 (0x30), Overflow=0, Beat_count=16.
- Same stream with In_valid low on every other cycle -> Acc_out=48. Out_valid rises exactly 1 cycle after the 16th accepted beat, and beats offered while In_valid=0 are ignored.
- ACC_WIDTH=6, 16 beats of value 6 -> Acc_out=32 (96 mod 64), Overflow=1 and held through DONE.
- Hold Out_ready=0 for 5 cycles in DONE -> Out_valid stays 1, Acc_out stays 48, In_ready=0; Start pulses are ignored. Out_ready=1 -> IDLE next cycle, Out_valid=0.
- Assert Rst_n low after 7 beats -> outputs go to 0 without waiting for a clock edge. After release, Start plus 16 beats of value 1 -> Acc_out=16.
- In IDLE, Start=1 and Clear=1 together -> stays IDLE, In_ready=0. In ACCUM, Clear after 3 beats -> IDLE, Beat_count=0, Acc_out=0.
